// File: rtl/hex_slot_store_if.sv
// hex_slot_store_if: bundles the switch-side inputs and the LED/7-seg side
// outputs of hex_slot_store.
//   master : the driver of the switches (board top or bench)
//   slave  : hex_slot_store itself
//   data_in/wr_en/disp_mode/scan_en/slot_sel  master -> slave
//   led_val/seg_out/cur_slot/count/full/overflow  slave -> master
interface hex_slot_store_if #(
  parameter int DATA_W = 4,
  parameter int NSLOTS = 4
);
  localparam int SW = $clog2(NSLOTS);

  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              disp_mode;
  logic              scan_en;
  logic [SW-1:0]     slot_sel;
  logic [DATA_W-1:0] led_val;
  logic [7:0]        seg_out;
  logic [SW-1:0]     cur_slot;
  logic [SW:0]       count;
  logic              full;
  logic              overflow;

  modport master (
    output data_in, wr_en, disp_mode, scan_en, slot_sel,
    input  led_val, seg_out, cur_slot, count, full, overflow
  );

  modport slave (
    input  data_in, wr_en, disp_mode, scan_en, slot_sel,
    output led_val, seg_out, cur_slot, count, full, overflow
  );
endinterface

// File: rtl/hex_slot_store.sv
// hex_slot_store: captures up to NSLOTS switch values into a slot bank while
// in store mode, and in display mode shows one slot on LEDs and a 7-seg digit,
// either manually selected or auto-scanned.
//   clk_2  : divided board clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : hex_slot_store_if.slave (switch inputs, LED/seg/status outputs)
// led_val, seg_out and cur_slot are registered (one cycle behind the shown
// index); count/full/overflow come straight from state.
module hex_slot_store #(
  parameter int DATA_W   = 4,
  parameter int NSLOTS   = 4,
  parameter int TICK_DIV = 2
) (
  input logic             clk_2,
  input logic             reset,
  hex_slot_store_if.slave bus
);
  localparam int SW = $clog2(NSLOTS);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NSLOTS-1:0][DATA_W-1:0] slots;
  logic [SW-1:0]     wr_ptr;
  logic [SW:0]       count_q;
  logic              ovf_q;
  logic [SW-1:0]     scan_idx;
  logic [TW-1:0]     tick;
  logic [DATA_W-1:0] led_q;
  logic [7:0]        seg_q;
  logic [SW-1:0]     cur_q;

  logic              full_w;
  logic              auto_on;
  logic [SW-1:0]     shown_idx;
  logic              shown_ok;
  logic [DATA_W-1:0] rd_val;
  logic              tick_wrap;
  logic              scan_last;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign full_w    = (count_q == (SW+1)'(NSLOTS));
  assign auto_on   = bus.disp_mode & bus.scan_en;
  assign shown_idx = auto_on ? scan_idx : bus.slot_sel;
  // Covers both the empty bank and a manual pick past the filled region.
  assign shown_ok  = ({1'b0, shown_idx} < count_q);
  assign tick_wrap = (tick == TW'(TICK_DIV - 1));
  // Also true when count is 0, so the scan index never leaves slot 0.
  assign scan_last = (({1'b0, scan_idx} + (SW+1)'(1)) >= count_q);

  // Compare-based read mux keeps indices in range for non-power-of-2 NSLOTS.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NSLOTS; i++)
      if (shown_idx == SW'(i)) rd_val = slots[i];
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      slots    <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      scan_idx <= '0;
      tick     <= '0;
      led_q    <= '0;
      seg_q    <= 8'h00;
      cur_q    <= '0;
    end else begin
      // Capture: only in store mode, never overwrites a full bank.
      if (!bus.disp_mode && bus.wr_en) begin
        if (full_w) begin
          ovf_q <= 1'b1;
        end else begin
          for (int i = 0; i < NSLOTS; i++)
            if (wr_ptr == SW'(i)) slots[i] <= bus.data_in;
          wr_ptr  <= (wr_ptr == SW'(NSLOTS - 1)) ? '0 : wr_ptr + SW'(1);
          count_q <= count_q + (SW+1)'(1);
        end
      end

      // Auto-scan dwell; leaving auto-scan rearms at slot 0, full dwell.
      if (auto_on) begin
        if (tick_wrap) begin
          tick     <= '0;
          scan_idx <= scan_last ? '0 : scan_idx + SW'(1);
        end else begin
          tick <= tick + TW'(1);
        end
      end else begin
        tick     <= '0;
        scan_idx <= '0;
      end

      // Display registers update only in display mode; store mode holds them.
      if (bus.disp_mode) begin
        cur_q <= shown_idx;
        led_q <= shown_ok ? rd_val : '0;
        seg_q <= shown_ok ? {1'b0, glyph(rd_val[3:0])} : 8'h40;
      end
    end
  end

  assign bus.led_val  = led_q;
  assign bus.seg_out  = seg_q;
  assign bus.cur_slot = cur_q;
  assign bus.count    = count_q;
  assign bus.full     = full_w;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_hex_slot_store.sv
// Directed bench for hex_slot_store (DATA_W=4, NSLOTS=4, TICK_DIV=2).
module tb_hex_slot_store;
  localparam int DATA_W   = 4;
  localparam int NSLOTS   = 4;
  localparam int TICK_DIV = 2;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_2 = ~clk_2;

  hex_slot_store_if #(.DATA_W(DATA_W), .NSLOTS(NSLOTS)) bus ();

  hex_slot_store #(.DATA_W(DATA_W), .NSLOTS(NSLOTS), .TICK_DIV(TICK_DIV)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_seg [6];
    logic [1:0] exp_cur [6];
    exp_seg = '{8'h06, 8'h06, 8'h5B, 8'h5B, 8'h06, 8'h06};
    exp_cur = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    bus.data_in = '0; bus.wr_en = 1'b0; bus.disp_mode = 1'b0;
    bus.scan_en = 1'b0; bus.slot_sel = '0;

    // Reset state
    reset = 1'b1; step(); step(); reset = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_led",   bus.led_val, 0);
    check("rst_seg",   bus.seg_out, 8'h00);
    check("rst_cur",   bus.cur_slot, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_full",  bus.full, 0);

    // Fill bank with 3,7,A,F
    bus.wr_en = 1'b1;
    bus.data_in = 4'h3; step();
    bus.data_in = 4'h7; step();
    bus.data_in = 4'hA; step();
    bus.data_in = 4'hF; step();
    bus.wr_en = 1'b0;
    check("fill_count", bus.count, 4);
    check("fill_full",  bus.full, 1);
    check("fill_ovf",   bus.overflow, 0);

    // Manual select 2
    bus.disp_mode = 1'b1; bus.slot_sel = 2'd2; step();
    check("sel2_led", bus.led_val, 4'hA);
    check("sel2_seg", bus.seg_out, 8'h77);
    check("sel2_cur", bus.cur_slot, 2);

    // Write while full -> sticky overflow, no overwrite
    bus.disp_mode = 1'b0; bus.wr_en = 1'b1; bus.data_in = 4'h5; step();
    bus.wr_en = 1'b0; step(); step();
    check("ovf_set",   bus.overflow, 1);
    check("ovf_count", bus.count, 4);
    bus.disp_mode = 1'b1; bus.slot_sel = 2'd0; step();
    check("sel0_led", bus.led_val, 4'h3);
    check("sel0_seg", bus.seg_out, 8'h4F);
    bus.slot_sel = 2'd3; step();
    check("sel3_led", bus.led_val, 4'hF);
    check("sel3_seg", bus.seg_out, 8'h71);
    check("ovf_stick", bus.overflow, 1);

    // Reset, then empty bank in display mode -> dash
    reset = 1'b1; step(); reset = 1'b0;
    check("rst2_ovf",   bus.overflow, 0);
    check("rst2_count", bus.count, 0);
    bus.disp_mode = 1'b1; bus.slot_sel = 2'd1; step();
    check("empty_seg", bus.seg_out, 8'h40);
    check("empty_led", bus.led_val, 0);
    check("empty_cur", bus.cur_slot, 1);

    // Store 1,2; outputs hold through store mode
    bus.disp_mode = 1'b0; bus.wr_en = 1'b1;
    bus.data_in = 4'h1; step();
    bus.data_in = 4'h2; step();
    bus.wr_en = 1'b0;
    check("two_count", bus.count, 2);
    check("hold_seg",  bus.seg_out, 8'h40);
    check("hold_cur",  bus.cur_slot, 1);
    bus.disp_mode = 1'b1; bus.slot_sel = 2'd3; step();
    check("past_seg", bus.seg_out, 8'h40);
    check("past_led", bus.led_val, 0);
    check("past_cur", bus.cur_slot, 3);
    bus.slot_sel = 2'd1; step();
    check("s1_seg", bus.seg_out, 8'h5B);
    check("s1_led", bus.led_val, 4'h2);

    // wr_en ignored in display mode
    bus.wr_en = 1'b1; bus.data_in = 4'h9;
    repeat (5) step();
    bus.wr_en = 1'b0;
    check("dispwr_count", bus.count, 2);
    check("dispwr_ovf",   bus.overflow, 0);

    // Auto-scan over two slots
    bus.scan_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("scan_cur%0d", i), bus.cur_slot, exp_cur[i]);
      check($sformatf("scan_seg%0d", i), bus.seg_out, exp_seg[i]);
    end

    // Reset mid-scan with wr_en high
    bus.wr_en = 1'b1; bus.data_in = 4'h7; reset = 1'b1; step();
    reset = 1'b0; bus.wr_en = 1'b0;
    check("mid_count", bus.count, 0);
    check("mid_led",   bus.led_val, 0);
    check("mid_seg",   bus.seg_out, 8'h00);
    check("mid_cur",   bus.cur_slot, 0);
    check("mid_ovf",   bus.overflow, 0);

    // Store B, d and show them
    bus.disp_mode = 1'b0; bus.scan_en = 1'b0; bus.wr_en = 1'b1;
    bus.data_in = 4'hB; step();
    bus.data_in = 4'hD; step();
    bus.wr_en = 1'b0;
    check("bd_count", bus.count, 2);
    bus.disp_mode = 1'b1; bus.slot_sel = 2'd0; step();
    check("b_seg", bus.seg_out, 8'h7C);
    check("b_led", bus.led_val, 4'hB);
    bus.slot_sel = 2'd1; step();
    check("d_seg", bus.seg_out, 8'h5E);
    check("d_led", bus.led_val, 4'hD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_slot_store.md
Name: hex_slot_store

Overview:
- Parametrised successor to the single-nibble latch-and-display board block.
- Captures up to NSLOTS values of DATA_W bits from the switches into an internal slot bank while in store mode.
- In display mode, shows one stored value on the LEDs and the 7-segment digit, either manually selected or auto-scanned.
- Sits at top level between the SWI inputs and the LED/SEG outputs, clocked by the divided board clock.

Parameters:
- DATA_W, 4, width of each stored value (4..8); only bits [3:0] drive the 7-seg glyph.
- NSLOTS, 4, number of storage slots (2..16).
- TICK_DIV, 2, clk_2 cycles each slot is shown while auto-scanning (>=1).

Ports:
- clk_2  input  1  clock; all state updates on posedge clk_2.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  value to capture.
- wr_en  input  1  capture strobe; sampled each cycle in store mode.
- disp_mode  input  1  0 = store mode, 1 = display mode.
- scan_en  input  1  in display mode: 1 = auto-scan, 0 = manual select.
- slot_sel  input  SW = $clog2(NSLOTS)  manual slot index.
- led_val  output  DATA_W  value of the shown slot (registered).
- seg_out  output  8  7-seg pattern {dp,g,f,e,d,c,b,a}, active-high (registered).
- cur_slot  output  SW  index of the slot currently shown (registered).
- count  output  SW+1  number of valid slots, 0..NSLOTS.
- full  output  1  count == NSLOTS.
- overflow  output  1  sticky; set by any write attempted while full.

Behaviour:
- Reset (synchronous, overrides everything): all slots 0, wr_ptr 0, count 0, overflow 0, scan index 0, tick counter 0, led_val 0, seg_out 8'h00, cur_slot 0.
- Store mode (disp_mode=0):
  - wr_en=1 and not full: slot[wr_ptr] <= data_in; wr_ptr and count increment.
  - wr_en=1 and full: the write is dropped and overflow <= 1. There is no overwrite.
  - wr_en is a level: every cycle it is high is a separate write.
  - Outputs hold their last registered values.
- Display mode (disp_mode=1):
  - wr_en is ignored; no write occurs and overflow is not set.
  - Manual (scan_en=0): shown index = slot_sel.
  - Auto (scan_en=1): a tick counter counts 0..TICK_DIV-1. On wrap, scan index advances, and wraps from count-1 to 0. Shown index = scan index.
  - Scan index and tick counter clear to 0 on any cycle where disp_mode=0 or scan_en=0. Re-entering auto-scan therefore always starts at slot 0 with a full TICK_DIV dwell.
  - Latency: led_val, seg_out and cur_slot reflect the shown index one cycle after the index/inputs change.
- Invalid display (count==0, or manual slot_sel >= count): led_val=0, seg_out=8'h40 (dash), cur_slot=shown index.
- Glyphs, dp=0, from low nibble: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Width rules: count is SW+1 bits so NSLOTS is representable. wr_ptr wraps to 0 after NSLOTS-1 but is unused once full; only reset empties the bank.
- Reset mid-scan or mid-write: the reset wins that cycle and the write is discarded.

Test Plan:
- Reset, store 3, 7, A, F (wr_en one cycle each) -> count=4, full=1, overflow=0. Manual select 2 in display mode -> next cycle led_val=4'hA, seg_out=8'h77.
- Bank full, one more write of 5 -> overflow=1 and stays 1. Manual select 0 -> led_val=3, seg_out=8'h4F; slot contents unchanged.
- Store 1, 2 (count=2), display, scan_en=1, TICK_DIV=2 -> cur_slot sequence 0,0,1,1,0,0…; seg_out alternates 06/5B with 1-cycle lag.
- Empty bank in display mode, any slot_sel -> seg_out=8'h40, led_val=0. With count=2, slot_sel=3 -> dash.
- wr_en=1 with disp_mode=1 for 5 cycles -> count unchanged, overflow unchanged.
- Assert reset mid-scan with wr_en=1 -> next cycle all outputs and count are 0. Store B, d -> glyphs 7C, 5E shown correctly.
